counter_stream_monitor: RTL

- Downstream consumer of the 8-bit free-running counter output of `top` (outCounter).
- Samples the counter stream every enabled cycle and checks that each sample equals the previous sample plus STEP, modulo 2^WIDTH.
- Acquires lock after a run of good steps, flags each break in the sequence, and keeps a saturating error count.
- Provides in-fabric sequence checking alongside the simulation asserts.

---
 rtl/counter_stream_monitor_if.sv | 24 ++
 rtl/counter_stream_monitor.sv | 95 +++++++++
 2 files changed

// File: rtl/counter_stream_monitor_if.sv
// Counter-stream monitor bus: sample qualifier/clear/value in, lock and error status out.
interface counter_stream_monitor_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_WIDTH = 16
);
  logic                 en;
  logic                 clr;
  logic [WIDTH-1:0]     inCounter;
  logic                 locked;
  logic                 mismatch;
  logic [WIDTH-1:0]     expected;
  logic [WIDTH-1:0]     lastBad;
  logic [ERR_WIDTH-1:0] errorCount;

  modport master (
    output en, clr, inCounter,
    input  locked, mismatch, expected, lastBad, errorCount
  );

  modport slave (
    input  en, clr, inCounter,
    output locked, mismatch, expected, lastBad, errorCount
  );
endinterface

// File: rtl/counter_stream_monitor.sv
// Checks that a sampled counter advances by STEP (mod 2^WIDTH) each enabled cycle,
// tracks lock, and records the last break plus a saturating error count.
module counter_stream_monitor #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  counter_stream_monitor_if.slave bus
);

  localparam int MRW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0]     STEP_V    = WIDTH'(STEP);
  localparam logic [MRW-1:0]       LOCK_LAST = MRW'(LOCK_COUNT - 1);
  localparam logic [MRW-1:0]       RUN_ONE   = MRW'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_ONE   = ERR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [MRW-1:0]   matchRun;
  logic [WIDTH-1:0] nxt;
  logic             good;

  always_comb begin
    nxt  = prev + STEP_V;
    good = (bus.inCounter == nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      prev           <= '0;
      matchRun       <= '0;
      bus.locked     <= 1'b0;
      bus.mismatch   <= 1'b0;
      bus.expected   <= '0;
      bus.lastBad    <= '0;
      bus.errorCount <= '0;
    end else begin
      bus.mismatch <= 1'b0;
      // clr outranks any sample in the same cycle, so a break seen then is dropped
      if (bus.clr) begin
        state          <= IDLE;
        matchRun       <= '0;
        bus.locked     <= 1'b0;
        bus.errorCount <= '0;
      end else if (bus.en) begin
        prev <= bus.inCounter;
        unique case (state)
          IDLE: begin
            matchRun <= '0;
            state    <= ACQUIRE;
          end
          ACQUIRE: begin
            if (!good) begin
              matchRun <= '0;
            end else if (matchRun == LOCK_LAST) begin
              matchRun   <= '0;
              bus.locked <= 1'b1;
              state      <= LOCKED;
            end else begin
              matchRun <= matchRun + RUN_ONE;
            end
          end
          LOCKED: begin
            if (!good) begin
              bus.mismatch <= 1'b1;
              bus.expected <= nxt;
              bus.lastBad  <= bus.inCounter;
              if (bus.errorCount != '1)
                bus.errorCount <= bus.errorCount + ERR_ONE;
              bus.locked   <= 1'b0;
              matchRun     <= '0;
              state        <= ACQUIRE;
            end
          end
          default: begin
            matchRun   <= '0;
            bus.locked <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
